vs_timer: RTL and testbench

//  VS-level Sstc timer, downstream of the hypervisor CSR file.
//  - Consumes htimedelta and henvcfg.STCE from the H-CSRs.
//  - Owns vstimecmp (0x24D) and, for RV32 only, vstimecmph (0x25D).
//  - Produces the virtual time (time + htimedelta) and VSTIP, which is ORed into hip/mip bit 6.
//  - Sits beside the H-CSR file in the privileged unit; CSR read values merge into the CSR read mux.

---
 rtl/vs_timer.sv | 89 ++++++++
 tb/tb_vs_timer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vs_timer.sv
// VS-level Sstc timer: owns vstimecmp(h), produces the virtual time and
// VSTIP, which feeds hip/mip bit 6.
module vs_timer #(
  parameter int XLEN  = 64,
  parameter int TIMEW = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TIMEW-1:0] MTIME,
  input  logic [TIMEW-1:0] HTIMEDELTA,
  input  logic             STCE,
  input  logic [1:0]       PrivilegeModeW,
  input  logic             VirtModeW,
  input  logic             CSRWriteM,
  input  logic [11:0]      CSRAdrM,
  input  logic [XLEN-1:0]  CSRWriteValM,
  output logic [XLEN-1:0]  CSRVTReadValM,
  output logic             IllegalCSRVTM,
  output logic [TIMEW-1:0] VIRTTIME,
  output logic             VSTIP
);

  localparam logic [11:0] ADR_VSTIMECMP  = 12'h24D;
  localparam logic [11:0] ADR_VSTIMECMPH = 12'h25D;
  localparam logic [1:0]  PRIV_S         = 2'd1;
  localparam logic [1:0]  PRIV_M         = 2'd3;
  localparam logic        IS_RV32        = (XLEN == 32);

  logic [TIMEW-1:0] vstimecmp_q, vstimecmp_d;
  logic [TIMEW-1:0] virttime_q, virttime_d;
  logic             vstip_q, vstip_d;
  logic             valid_q;

  logic             hit_lo, hit_hi, adr_ok, priv_ok, legal, wr_en;
  logic [XLEN-1:0]  rd_val;

  assign hit_lo  = (CSRAdrM == ADR_VSTIMECMP);
  assign hit_hi  = (CSRAdrM == ADR_VSTIMECMPH);
  assign adr_ok  = hit_lo | (hit_hi & IS_RV32);
  // VS may touch vstimecmp only when the hypervisor has enabled Sstc for it.
  assign priv_ok = (PrivilegeModeW == PRIV_M) |
                   ((PrivilegeModeW == PRIV_S) & (~VirtModeW | STCE));
  assign legal   = adr_ok & priv_ok;
  assign wr_en   = CSRWriteM & legal;

  assign IllegalCSRVTM = (hit_lo | hit_hi) & ~legal;
  assign CSRVTReadValM = legal ? rd_val : '0;

  generate
    if (XLEN == 32) begin : g_rv32
      always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        vstimecmp_d = vstimecmp_q;
        if (wr_en & hit_lo) vstimecmp_d[31:0]       = CSRWriteValM;
        if (wr_en & hit_hi) vstimecmp_d[TIMEW-1:32] = CSRWriteValM;
        rd_val = hit_hi ? vstimecmp_q[TIMEW-1:32] : vstimecmp_q[31:0];
      end
    end else begin : g_rv64
      always_comb begin
        vstimecmp_d = wr_en ? CSRWriteValM : vstimecmp_q;
        rd_val      = vstimecmp_q;
      end
    end
  endgenerate

  assign virttime_d = MTIME + HTIMEDELTA;

  // A write this cycle suppresses the stale compare; the next compare sees the new value.
  assign vstip_d = ~wr_en & STCE & valid_q & (virttime_q >= vstimecmp_q);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      vstimecmp_q <= '1;
      virttime_q  <= '0;
      vstip_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      vstimecmp_q <= vstimecmp_d;
      virttime_q  <= virttime_d;
      vstip_q     <= vstip_d;
      valid_q     <= 1'b1;
    end
  end

  assign VIRTTIME = virttime_q;
  assign VSTIP    = vstip_q;

endmodule

// File: tb/tb_vs_timer.sv
// Self-checking bench for vs_timer: RV64 and RV32 instances side by side,
// registered outputs checked through a due-cycle scoreboard.
module tb_vs_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] mtime, hdelta;
  logic        stce, virt;
  logic [1:0]  priv;
  logic [11:0] adr;
  logic        wr64, wr32;
  logic [63:0] wval64, rd64, vt64, vt32;
  logic [31:0] wval32, rd32;
  logic        ill64, ill32, vstip64, vstip32;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vs_timer #(.XLEN(64), .TIMEW(64)) u_rv64 (
    .clk(clk), .reset(reset), .MTIME(mtime), .HTIMEDELTA(hdelta), .STCE(stce),
    .PrivilegeModeW(priv), .VirtModeW(virt), .CSRWriteM(wr64), .CSRAdrM(adr),
    .CSRWriteValM(wval64), .CSRVTReadValM(rd64), .IllegalCSRVTM(ill64),
    .VIRTTIME(vt64), .VSTIP(vstip64)
  );

  vs_timer #(.XLEN(32), .TIMEW(64)) u_rv32 (
    .clk(clk), .reset(reset), .MTIME(mtime), .HTIMEDELTA(hdelta), .STCE(stce),
    .PrivilegeModeW(priv), .VirtModeW(virt), .CSRWriteM(wr32), .CSRAdrM(adr),
    .CSRWriteValM(wval32), .CSRVTReadValM(rd32), .IllegalCSRVTM(ill32),
    .VIRTTIME(vt32), .VSTIP(vstip32)
  );

  always #5 clk = ~clk;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    int          due;
    int          sel;   // 0 vt64, 1 vstip64, 2 vt32, 3 vstip32
    logic [63:0] exp;
  } sb_t;

  sb_t sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_push(input string tag, input int sel, input logic [63:0] exp, input int lat);
    sb.push_back('{tag: tag, due: cyc + lat, sel: sel, exp: exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].sel)
          0:       check(sb[i].tag, vt64, sb[i].exp);
          1:       check(sb[i].tag, {63'd0, vstip64}, sb[i].exp);
          2:       check(sb[i].tag, vt32, sb[i].exp);
          default: check(sb[i].tag, {63'd0, vstip32}, sb[i].exp);
        endcase
        sb.delete(i);
      end
    end
  end

  initial begin
    reset = 1'b0; mtime = 64'h50; hdelta = 64'h5; stce = 1'b1;
    priv = 2'd3; virt = 1'b0; adr = 12'h24D;
    wr64 = 1'b0; wr32 = 1'b0; wval64 = '0; wval32 = '0;

    // Reset state
    sb_push("rst_vt64", 0, 64'd0, 1);
    sb_push("rst_vstip64", 1, 64'd0, 1);
    sb_push("rst_vt32", 2, 64'd0, 1);
    sb_push("rst_vstip32", 3, 64'd0, 1);
    step(); step();
    sb_push("rst_vt64_hold", 0, 64'd0, 0);
    check("rst_rd64", rd64, ONES);
    check("rst_ill64", {63'd0, ill64}, 64'd0);
    check("rst_rd32_lo", {32'd0, rd32}, 64'hFFFF_FFFF);
    adr = 12'h25D; #1;
    check("rst_rd32_hi", {32'd0, rd32}, 64'hFFFF_FFFF);
    check("rv64_25d_ill", {63'd0, ill64}, 64'd1);
    check("rv64_25d_rd", rd64, 64'd0);
    adr = 12'h24D;

    reset = 1'b1;
    sb_push("rel_vt64", 0, 64'h55, 1);
    sb_push("rel_vstip64_a", 1, 64'd0, 1);
    sb_push("rel_vstip64_b", 1, 64'd0, 2);
    step();

    // Basic compare: virt 0x74 < 0x80, then 0x80 >= 0x80
    mtime = 64'd100; hdelta = 64'h10; wr64 = 1'b1; wval64 = 64'h80;
    sb_push("t2_vt", 0, 64'h74, 1);
    sb_push("t2_vstip_wr", 1, 64'd0, 1);
    step();
    wr64 = 1'b0; #1;
    check("t2_rd", rd64, 64'h80);
    sb_push("t2_vstip_lt", 1, 64'd0, 1);
    step();
    mtime = 64'h70;
    sb_push("t2_vt_eq", 0, 64'h80, 1);
    sb_push("t2_vstip_lat1", 1, 64'd0, 1);
    sb_push("t2_vstip_lat2", 1, 64'd1, 2);
    step(); step();

    // Write while pending: write wins, no pulse afterwards
    wr64 = 1'b1; wval64 = 64'h1000;
    sb_push("t3_wr_wins", 1, 64'd0, 1);
    step();
    wr64 = 1'b0;
    sb_push("t3_new_cmp", 1, 64'd0, 1);
    for (int i = 0; i < 6; i++) begin
      mtime = 64'h70 + 64'(i) * 64'h200;
      sb_push("t3_no_pulse", 1, 64'd0, 2);
      step();
    end
    mtime = 64'hFF0;
    sb_push("t3_reach", 1, 64'd1, 2);
    step(); step();
    sb_push("t3_level", 1, 64'd1, 1);
    step();

    // STCE gating
    stce = 1'b0;
    sb_push("stce_off", 1, 64'd0, 1);
    step();
    check("stce_off_cmp_held", rd64, 64'h1000);
    stce = 1'b1;
    sb_push("stce_on", 1, 64'd1, 1);
    step();

    // htimedelta decrease clears
    hdelta = 64'd0;
    sb_push("dec_vt", 0, 64'hFF0, 1);
    sb_push("dec_vstip_lat1", 1, 64'd1, 1);
    sb_push("dec_vstip_lat2", 1, 64'd0, 2);
    step(); step();

    // Wrap of virtual time
    hdelta = 64'hFFFF_FFFF_FFFF_FFF0; mtime = 64'h20; wr64 = 1'b1; wval64 = 64'h8;
    sb_push("wrap_vt", 0, 64'h10, 1);
    sb_push("wrap_vstip_wr", 1, 64'd0, 1);
    sb_push("wrap_vstip", 1, 64'd1, 2);
    step();
    wr64 = 1'b0;
    step();
    mtime = 64'h0F;
    sb_push("wrap_vt_max", 0, ONES, 1);
    sb_push("wrap_vstip_max", 1, 64'd1, 2);
    step();
    mtime = 64'h10;
    sb_push("wrap_vt_zero", 0, 64'd0, 1);
    sb_push("wrap_clear", 1, 64'd0, 2);
    step(); step();

    // Access legality
    priv = 2'd1; virt = 1'b1; stce = 1'b0; wr64 = 1'b1; wval64 = 64'h5555; #1;
    check("vs_stce0_ill", {63'd0, ill64}, 64'd1);
    check("vs_stce0_rd", rd64, 64'd0);
    step();
    wr64 = 1'b0; priv = 2'd3; virt = 1'b0; #1;
    check("vs_wr_blocked", rd64, 64'h8);
    priv = 2'd1; virt = 1'b1; stce = 1'b1; wr64 = 1'b1; wval64 = 64'h3333; #1;
    check("vs_stce1_ill", {63'd0, ill64}, 64'd0);
    step();
    wr64 = 1'b0; priv = 2'd3; virt = 1'b0; #1;
    check("vs_wr_ok", rd64, 64'h3333);
    priv = 2'd0; #1;
    check("u_ill", {63'd0, ill64}, 64'd1);
    check("u_rd", rd64, 64'd0);
    virt = 1'b1; #1;
    check("vu_ill", {63'd0, ill64}, 64'd1);
    priv = 2'd1; virt = 1'b0; stce = 1'b0; #1;
    check("hs_ill", {63'd0, ill64}, 64'd0);
    check("hs_rd", rd64, 64'h3333);
    priv = 2'd3; stce = 1'b1; adr = 12'h14D; #1;
    check("other_ill", {63'd0, ill64}, 64'd0);
    check("other_rd", rd64, 64'd0);

    // RV32 split access
    hdelta = 64'd0; mtime = 64'd0;
    adr = 12'h25D; wr32 = 1'b1; wval32 = 32'h1; #1;
    check("rv32_25d_ill", {63'd0, ill32}, 64'd0);
    step();
    adr = 12'h24D; wval32 = 32'h0;
    step();
    wr32 = 1'b0; #1;
    check("rv32_lo", {32'd0, rd32}, 64'd0);
    adr = 12'h25D; #1;
    check("rv32_hi", {32'd0, rd32}, 64'd1);
    adr = 12'h24D;
    mtime = 64'hFFFF_FFFF;
    sb_push("rv32_vt", 2, 64'hFFFF_FFFF, 1);
    sb_push("rv32_below", 3, 64'd0, 2);
    step();
    mtime = 64'h1_0000_0000;
    sb_push("rv32_reach", 3, 64'd1, 2);
    step(); step();

    // Reset mid-operation drops pending VSTIP
    reset = 1'b0;
    sb_push("midrst_vstip32", 3, 64'd0, 1);
    sb_push("midrst_vt32", 2, 64'd0, 1);
    sb_push("midrst_vt64", 0, 64'd0, 1);
    step();
    adr = 12'h25D; #1;
    check("midrst_rd32_hi", {32'd0, rd32}, 64'hFFFF_FFFF);
    reset = 1'b1; adr = 12'h24D;
    step();

    repeat (4) step();
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
